// File: rtl/uart_rx_frame.sv
// UART receive frame engine: oversampled start detection with glitch rejection,
// LSB-first deserialisation, optional parity check and stop-bit check.
module uart_rx_frame #(
  parameter int DATA_LENGTH = 8,
  parameter int OVERSAMPLE  = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYPE,
  output logic [DATA_LENGTH-1:0] P_DATA,
  output logic                   Data_valid,
  output logic                   Par_err,
  output logic                   Stp_err
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_LENGTH + 1);

  localparam logic [SW-1:0] SAMP_A    = SW'(H - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(H);
  localparam logic [SW-1:0] SAMP_DEC  = SW'(H + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_LENGTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]             state_reg;
  logic [SW-1:0]          samp_cnt_reg;
  logic [BW-1:0]          bit_cnt_reg;
  logic [DATA_LENGTH-1:0] shift_reg;
  logic                   cap_a_reg;
  logic                   cap_b_reg;
  logic                   par_en_reg;
  logic                   par_type_reg;
  logic                   par_fail_reg;

  logic maj;
  logic at_dec;
  logic at_last;

  // The third capture is the live line value, so the vote completes at H+1.
  always_comb begin
    maj     = (cap_a_reg & cap_b_reg) | (cap_a_reg & RX_IN) | (cap_b_reg & RX_IN);
    at_dec  = (samp_cnt_reg == SAMP_DEC);
    at_last = (samp_cnt_reg == SAMP_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      samp_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      cap_a_reg    <= 1'b1;
      cap_b_reg    <= 1'b1;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
      par_fail_reg <= 1'b0;
      P_DATA       <= '0;
      Data_valid   <= 1'b0;
      Par_err      <= 1'b0;
      Stp_err      <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;

      if (state_reg != IDLE) begin
        if (samp_cnt_reg == SAMP_A) cap_a_reg <= RX_IN;
        if (samp_cnt_reg == SAMP_B) cap_b_reg <= RX_IN;
        samp_cnt_reg <= at_last ? '0 : samp_cnt_reg + SW'(1);
      end

      case (state_reg)
        IDLE: begin
          // The detect cycle itself is sample 0 of the start bit.
          if (!RX_IN) begin
            state_reg    <= START;
            samp_cnt_reg <= SW'(1);
            bit_cnt_reg  <= '0;
            par_en_reg   <= PAR_EN;
            par_type_reg <= PAR_TYPE;
            par_fail_reg <= 1'b0;
          end
        end
        START: begin
          if (at_dec && maj) begin
            state_reg    <= IDLE;
            samp_cnt_reg <= '0;
          end else if (at_last) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (at_dec) shift_reg <= {maj, shift_reg[DATA_LENGTH-1:1]};
          if (at_last) begin
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_reg <= '0;
              state_reg   <= par_en_reg ? PARITY : STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
          end
        end
        PARITY: begin
          if (at_dec && (maj != ((^shift_reg) ^ par_type_reg))) par_fail_reg <= 1'b1;
          if (at_last) state_reg <= STOP;
        end
        STOP: begin
          // Leave half a bit early so the next start edge is never missed.
          if (at_dec) begin
            state_reg    <= IDLE;
            samp_cnt_reg <= '0;
            if (!maj) begin
              Stp_err <= 1'b1;
            end else if (par_fail_reg) begin
              Par_err <= 1'b1;
            end else begin
              Data_valid <= 1'b1;
              P_DATA     <= shift_reg;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          samp_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: builds a per-cycle line waveform from frame
// descriptions, derives expected strobes and P_DATA per cycle, then replays it.
module tb_uart_rx_frame;

  localparam int DL = 8;
  localparam int OS = 8;
  localparam int H  = OS / 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYPE = 1'b0;
  logic [DL-1:0] P_DATA;
  logic          Data_valid;
  logic          Par_err;
  logic          Stp_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic line_q[$];
  logic rst_q[$];
  logic pe_q[$];
  logic pt_q[$];
  int            ev_cyc[$];
  int            ev_kind[$];
  logic [DL-1:0] ev_data[$];

  logic [2:0]    exp_str[];
  logic [DL-1:0] exp_pd[];
  logic [DL-1:0] exp_evd[];

  uart_rx_frame #(.DATA_LENGTH(DL), .OVERSAMPLE(OS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYPE   (PAR_TYPE),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid),
    .Par_err    (Par_err),
    .Stp_err    (Stp_err)
  );

  always #5 CLK = ~CLK;

  task automatic push_sample(input logic v, input logic r, input logic pe, input logic pt);
    line_q.push_back(v);
    rst_q.push_back(r);
    pe_q.push_back(pe);
    pt_q.push_back(pt);
  endtask

  task automatic add_idle(input int n, input logic r = 1'b0);
    for (int i = 0; i < n; i++) push_sample(1'b1, r, 1'($urandom), 1'($urandom));
  endtask

  // gbit/gsamp: one inverted sample inside bit gbit (-1 = none).
  // abort_at: frame sample index at which RST is pulsed and the frame cut (-1 = none).
  task automatic add_frame(input logic [DL-1:0] d, input logic pe, input logic pt,
                           input logic par_ok, input logic stop,
                           input int gbit, input int gsamp, input int abort_at);
    int   s;
    logic pbit;
    logic bits[$];
    s    = line_q.size();
    pbit = (^d) ^ pt ^ ~par_ok;
    bits.push_back(1'b0);
    for (int i = 0; i < DL; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      for (int j = 0; j < OS; j++) begin
        int   k;
        logic v;
        k = b * OS + j;
        v = bits[b] ^ ((b == gbit) && (j == gsamp));
        if (abort_at < 0 || k <= abort_at)
          push_sample(v, logic'(k == abort_at),
                      (k == 0) ? pe : 1'($urandom), (k == 0) ? pt : 1'($urandom));
      end
    end
    if (abort_at < 0) begin
      ev_cyc.push_back(s + (1 + DL + int'(pe)) * OS + H + 2);
      if (!stop)             ev_kind.push_back(2);
      else if (pe && !par_ok) ev_kind.push_back(1);
      else                   ev_kind.push_back(0);
      ev_data.push_back(d);
    end
  endtask

  initial begin
    int            total;
    logic [DL-1:0] pd;

    // Power-on reset, then directed scenarios.
    add_idle(3, 1'b1);
    add_idle(5);
    add_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, -1);
    add_idle(3);
    add_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, -1);
    add_idle(2);
    add_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, -1);
    add_idle(OS + 2);
    add_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, -1);
    add_idle(4);
    push_sample(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    push_sample(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    add_idle(H + 2 + OS);
    add_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, -1);
    add_idle(3);
    add_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 3, H, -1);
    add_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, -1);
    add_idle(3);
    add_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 4 * OS + 2);
    add_idle(5);
    add_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, -1);
    add_idle(2);

    // Randomised frames with occasional errors, glitches and zero gaps.
    for (int f = 0; f < 24; f++) begin
      logic [DL-1:0] d;
      logic          pe, pt, pok, stp;
      int            gb, gs;
      d   = DL'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      pok = ($urandom_range(0, 3) != 0);
      stp = ($urandom_range(0, 7) != 0);
      gb  = -1;
      if ($urandom_range(0, 1) == 1) gb = int'($urandom_range(0, 1 + DL + int'(pe)));
      gs  = H - 1 + int'($urandom_range(0, 2));
      add_frame(d, pe, pt, pok, stp, gb, gs, -1);
      if (stp) add_idle(int'($urandom_range(0, 3)));
      else     add_idle(OS + 2);
    end
    add_idle(2 * OS + H + 4);

    // Expected per-cycle strobes {Data_valid, Par_err, Stp_err} and P_DATA.
    total   = line_q.size();
    exp_str = new[total];
    exp_pd  = new[total];
    exp_evd = new[total];
    for (int c = 0; c < total; c++) begin
      exp_str[c] = 3'b000;
      exp_evd[c] = '0;
    end
    for (int e = 0; e < ev_cyc.size(); e++) begin
      exp_str[ev_cyc[e]] = (ev_kind[e] == 0) ? 3'b100 : (ev_kind[e] == 1) ? 3'b010 : 3'b001;
      exp_evd[ev_cyc[e]] = ev_data[e];
    end
    pd = '0;
    for (int c = 0; c < total; c++) begin
      if (c > 0 && rst_q[c-1]) pd = '0;
      if (exp_str[c] == 3'b100) pd = exp_evd[c];
      exp_pd[c] = pd;
    end

    for (int c = 0; c < total; c++) begin
      @(posedge CLK);
      #1;
      RX_IN    = line_q[c];
      RST      = rst_q[c];
      PAR_EN   = pe_q[c];
      PAR_TYPE = pt_q[c];
      @(negedge CLK);
      if (c > 0) begin
        n_assert++;
        assert ({Data_valid, Par_err, Stp_err} === exp_str[c]) else begin
          n_fail++;
          $error("FAIL strobes cycle=%0d observed dv/pe/se=%b expected=%b",
                 c, {Data_valid, Par_err, Stp_err}, exp_str[c]);
        end
        n_assert++;
        assert (P_DATA === exp_pd[c]) else begin
          n_fail++;
          $error("FAIL p_data cycle=%0d observed=%h expected=%h", c, P_DATA, exp_pd[c]);
        end
        if (exp_str[c] != 3'b000)
          $display("cycle %0d: frame end dv/pe/se=%b P_DATA=%h (expected %b %h)",
                   c, {Data_valid, Par_err, Stp_err}, P_DATA, exp_str[c], exp_pd[c]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
